// File: rtl/mmio_gpio_pkg.sv
// Shared register map and helpers for the memory-mapped GPIO peripheral.
package mmio_gpio_pkg;

    localparam logic [2:0] GPIO_OUT     = 3'd0;
    localparam logic [2:0] GPIO_DIR     = 3'd1;
    localparam logic [2:0] GPIO_SET     = 3'd2;
    localparam logic [2:0] GPIO_CLR     = 3'd3;
    localparam logic [2:0] GPIO_IN      = 3'd4;
    localparam logic [2:0] GPIO_RISE_EN = 3'd5;
    localparam logic [2:0] GPIO_FALL_EN = 3'd6;
    localparam logic [2:0] GPIO_STATUS  = 3'd7;

    localparam logic [31:0] GPIO_DEFAULT_BASE = 32'hFFFF_F800;

    // Expand the four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strobe_mask(input logic [3:0] wstrb);
        logic [31:0] m;
        m = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{wstrb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous pad inputs.
module gpio_sync #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    // Shift the raw input through STAGES flops; the oldest stage is the output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/mmio_gpio.sv
// GPIO peripheral on the picorv32 native bus: out/dir, atomic set/clear,
// synchronised inputs, sticky edge status and a level interrupt.
module mmio_gpio
    import mmio_gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 6,
    parameter logic [31:0] BASE_ADDR   = GPIO_DEFAULT_BASE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_valid,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    output logic             sel,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    typedef logic [WIDTH-1:0] bits_t;

    bits_t out_q, out_d;
    bits_t dir_q, dir_d;
    bits_t rise_en_q, rise_en_d;
    bits_t fall_en_q, fall_en_d;
    bits_t status_q, status_d;
    bits_t prev_q;
    bits_t sync_in_s, rise_s, fall_s, wmask_s, wbits_s, w1c_s;

    logic        ready_q;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] lane_mask_s, rd_val_s;
    logic [2:0]  offset_s;
    logic        req_s, wr_s;
    logic        unused_bits_s;

    assign sel         = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]);
    // A request is taken only on the first selected cycle while ready is low.
    assign req_s       = sel && !ready_q;
    assign wr_s        = req_s && (mem_wstrb != 4'b0000);
    assign offset_s    = mem_addr[4:2];
    assign lane_mask_s = strobe_mask(mem_wstrb);
    assign wmask_s     = lane_mask_s[WIDTH-1:0];
    assign wbits_s     = mem_wdata[WIDTH-1:0] & wmask_s;

    assign unused_bits_s = ^{mem_addr[1:0], mem_wdata, lane_mask_s};

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (resetn),
        .d_i    (gpio_in),
        .q_o    (sync_in_s)
    );

    assign rise_s = sync_in_s & ~prev_q;
    assign fall_s = ~sync_in_s & prev_q;

    // Register writes, W1C status merge and interrupt next-state.
    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c_s     = '0;
        if (wr_s) begin
            case (offset_s)
                GPIO_OUT:     out_d     = (out_q & ~wmask_s) | wbits_s;
                GPIO_DIR:     dir_d     = (dir_q & ~wmask_s) | wbits_s;
                GPIO_SET:     out_d     = out_q | wbits_s;
                GPIO_CLR:     out_d     = out_q & ~wbits_s;
                GPIO_RISE_EN: rise_en_d = (rise_en_q & ~wmask_s) | wbits_s;
                GPIO_FALL_EN: fall_en_d = (fall_en_q & ~wmask_s) | wbits_s;
                GPIO_STATUS:  w1c_s     = wbits_s;
                default:      w1c_s     = '0;
            endcase
        end else begin
            w1c_s = '0;
        end
        // New events are ORed in after the clear so they win a collision.
        status_d = (status_q & ~w1c_s) | (rise_s & rise_en_q) | (fall_s & fall_en_q);
        irq_d    = |(status_d & (rise_en_q | fall_en_q));
    end

    // Read-data mux; zero outside an accepted read so rdata idles at 0.
    always_comb begin
        rd_val_s = 32'h0000_0000;
        case (offset_s)
            GPIO_OUT:     rd_val_s = 32'(out_q);
            GPIO_DIR:     rd_val_s = 32'(dir_q);
            GPIO_IN:      rd_val_s = 32'(sync_in_s);
            GPIO_RISE_EN: rd_val_s = 32'(rise_en_q);
            GPIO_FALL_EN: rd_val_s = 32'(fall_en_q);
            GPIO_STATUS:  rd_val_s = 32'(status_q);
            default:      rd_val_s = 32'h0000_0000;
        endcase
        if (req_s && !wr_s) begin
            rdata_d = rd_val_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // State and bus response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'h0000_0000;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= sync_in_s;
            ready_q   <= req_s;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign gpio_out  = out_q;
    assign gpio_oe   = dir_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_mmio_gpio.sv
// Scoreboard bench for mmio_gpio: a cycle-level reference model predicts bus
// responses and pad outputs; a negedge monitor compares against the DUT.
module tb_mmio_gpio;

    localparam int          W    = 6;
    localparam int          S    = 2;
    localparam logic [31:0] BASE = 32'hFFFF_F800;

    logic          clk       = 1'b0;
    logic          resetn    = 1'b0;
    logic          mem_valid = 1'b0;
    logic [31:0]   mem_addr  = 32'h0;
    logic [31:0]   mem_wdata = 32'h0;
    logic [3:0]    mem_wstrb = 4'h0;
    logic [W-1:0]  gpio_in   = '0;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          sel;
    logic [W-1:0]  gpio_out;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    mmio_gpio #(.WIDTH(W), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .sel(sel), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] ws);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) if (ws[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed { logic is_rd; logic [31:0] data; } exp_t;
    exp_t exp_q[$];

    logic [W-1:0] m_out = '0, m_dir = '0, m_ren = '0, m_fen = '0, m_stat = '0;
    logic         m_irq = 1'b0, m_ack = 1'b0;
    logic [W-1:0] sh [S+2];   // sh[i] = pad value sampled i edges ago

    always @(posedge clk or negedge resetn) begin
        logic [W-1:0] syn, prv, wm, wb, old_ren, old_fen, w1c;
        logic [31:0]  lm;
        logic [2:0]   off;
        logic         acc;
        exp_t         e;
        if (!resetn) begin
            m_out = '0; m_dir = '0; m_ren = '0; m_fen = '0; m_stat = '0;
            m_irq = 1'b0; m_ack = 1'b0;
            for (int i = 0; i < S + 2; i++) sh[i] = '0;
            exp_q.delete();
        end else begin
            for (int i = S + 1; i > 0; i--) sh[i] = sh[i-1];
            sh[0] = gpio_in;
            syn = sh[S];
            prv = sh[S+1];
            acc = mem_valid && (mem_addr[31:5] == BASE[31:5]) && !m_ack;
            m_ack = acc;
            old_ren = m_ren;
            old_fen = m_fen;
            w1c = '0;
            off = mem_addr[4:2];
            lm  = lanes(mem_wstrb);
            wm  = lm[W-1:0];
            wb  = mem_wdata[W-1:0] & wm;
            if (acc && mem_wstrb == 4'b0000) begin
                e.is_rd = 1'b1;
                case (off)
                    3'd0: e.data = 32'(m_out);
                    3'd1: e.data = 32'(m_dir);
                    3'd4: e.data = 32'(syn);
                    3'd5: e.data = 32'(m_ren);
                    3'd6: e.data = 32'(m_fen);
                    3'd7: e.data = 32'(m_stat);
                    default: e.data = 32'h0;
                endcase
                exp_q.push_back(e);
            end else if (acc) begin
                e.is_rd = 1'b0;
                e.data  = 32'h0;
                exp_q.push_back(e);
                case (off)
                    3'd0: m_out = (m_out & ~wm) | wb;
                    3'd1: m_dir = (m_dir & ~wm) | wb;
                    3'd2: m_out = m_out | wb;
                    3'd3: m_out = m_out & ~wb;
                    3'd5: m_ren = (m_ren & ~wm) | wb;
                    3'd6: m_fen = (m_fen & ~wm) | wb;
                    3'd7: w1c = wb;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~w1c) | (syn & ~prv & old_ren) | (~syn & prv & old_fen);
            m_irq  = |(m_stat & (old_ren | old_fen));
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            check("sel", 32'(sel), 32'(mem_valid && (mem_addr[31:5] == BASE[31:5])));
            check("gpio_out", 32'(gpio_out), 32'(m_out));
            check("gpio_oe", 32'(gpio_oe), 32'(m_dir));
            check("irq", 32'(irq), 32'(m_irq));
            check("ready", 32'(mem_ready), 32'(exp_q.size() > 0));
            if (mem_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.is_rd) check("rdata", mem_rdata, e.data);
            end else if (!mem_ready) begin
                check("rdata_idle", mem_rdata, 32'h0);
            end
        end
    end

    // ---------------- driver (entered and left at negedge+1) ----------------
    task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                       input bit expect_ack, output logic [31:0] rd);
        int waited;
        bit got;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws;
        got = 1'b0; waited = 0; rd = 32'h0;
        while (!got && waited < 4) begin
            @(negedge clk);
            waited++;
            if (mem_ready) begin
                got = 1'b1;
                rd  = mem_rdata;
            end
        end
        #1;
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        if (expect_ack) check("ack_latency", 32'(waited), 32'd1);
        else            check("no_ack", 32'(got), 32'd0);
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] ra(input int off);
        return BASE + 32'(off * 4);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, tmp;
        int cnt;

        repeat (3) @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk); #1;
        check("rst_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int o = 0; o < 8; o++) begin
            bus(ra(o), 32'h0, 4'h0, 1'b1, rd);
            check("rst_read", rd, 32'h0);
        end

        // byte-masked write of DIR, and upper lanes ignored
        bus(ra(1), 32'h0000_003F, 4'b0001, 1'b1, rd);
        check("dir_oe", 32'(gpio_oe), 32'h3F);
        bus(ra(1), 32'hFFFF_FF00, 4'b1110, 1'b1, rd);
        bus(ra(1), 32'h0, 4'h0, 1'b1, rd);
        check("dir_read", rd, 32'h3F);

        // set / clear
        bus(ra(0), 32'h0000_0005, 4'hF, 1'b1, rd);
        bus(ra(2), 32'h0000_0030, 4'hF, 1'b1, rd);
        check("set_out", 32'(gpio_out), 32'h35);
        bus(ra(3), 32'h0000_0001, 4'hF, 1'b1, rd);
        check("clr_out", 32'(gpio_out), 32'h34);
        bus(ra(2), 32'h0, 4'h0, 1'b1, rd);
        check("set_read0", rd, 32'h0);

        // edge interrupt
        bus(ra(5), 32'h02, 4'hF, 1'b1, rd);
        bus(ra(6), 32'h00, 4'hF, 1'b1, rd);
        gpio_in[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("irq_before", 32'(irq), 32'h0);
        @(negedge clk);
        check("irq_after3", 32'(irq), 32'h1);
        #1;
        bus(ra(7), 32'h0, 4'h0, 1'b1, rd);
        check("status_rise", rd, 32'h02);
        gpio_in[1] = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        bus(ra(7), 32'h0, 4'h0, 1'b1, rd);
        check("status_fall_ignored", rd, 32'h02);

        // clear, then W1C colliding with a new rising edge
        bus(ra(7), 32'h02, 4'b0001, 1'b1, rd);
        check("w1c_irq0", 32'(irq), 32'h0);
        gpio_in[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        bus(ra(7), 32'h02, 4'b0001, 1'b1, rd);
        check("collide_irq", 32'(irq), 32'h1);
        bus(ra(7), 32'h0, 4'h0, 1'b1, rd);
        check("collide_status", rd, 32'h02);
        bus(ra(5), 32'h00, 4'hF, 1'b1, rd);
        check("mask_irq", 32'(irq), 32'h0);
        bus(ra(7), 32'h0, 4'h0, 1'b1, rd);
        check("mask_keeps_status", rd, 32'h02);
        bus(ra(5), 32'h02, 4'hF, 1'b1, rd);
        bus(ra(7), 32'h02, 4'b0001, 1'b1, rd);
        check("w1c_late_irq", 32'(irq), 32'h0);
        bus(ra(7), 32'h0, 4'h0, 1'b1, rd);
        check("w1c_late_status", rd, 32'h0);

        // back-to-back: valid held high yields one ready per two cycles
        mem_valid = 1'b1; mem_addr = ra(1); mem_wstrb = 4'h0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ready) cnt++;
        end
        #1 mem_valid = 1'b0;
        check("b2b_readies", 32'(cnt), 32'd2);
        @(negedge clk); #1;

        // decode boundary
        mem_valid = 1'b1; mem_addr = BASE + 32'h20; mem_wstrb = 4'h0;
        #1 check("sel_miss", 32'(sel), 32'h0);
        bus(BASE + 32'h20, 32'h0, 4'h0, 1'b0, rd);
        mem_valid = 1'b1; mem_addr = BASE + 32'h1C;
        #1 check("sel_hit", 32'(sel), 32'h1);
        bus(BASE + 32'h1C, 32'h0, 4'h0, 1'b1, rd);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                tmp = $urandom;
                gpio_in = gpio_in ^ tmp[W-1:0];
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #1;
            end else if (r == 3) begin
                if ($urandom_range(0, 1) == 1) bus(BASE + 32'h20 + 32'($urandom_range(0, 7) * 4), $urandom, 4'hF, 1'b0, rd);
                else                           bus(BASE - 32'h4, $urandom, 4'h0, 1'b0, rd);
            end else begin
                tmp = $urandom;
                bus(ra($urandom_range(0, 7)), $urandom, ($urandom_range(0, 1) == 1) ? tmp[3:0] : 4'h0, 1'b1, rd);
            end
        end

        // reset in the middle of an access
        bus(ra(0), 32'h2A, 4'hF, 1'b1, rd);
        bus(ra(1), 32'h15, 4'hF, 1'b1, rd);
        mem_valid = 1'b1; mem_addr = ra(1); mem_wdata = 32'h3F; mem_wstrb = 4'hF;
        #2 resetn = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", 32'(mem_ready), 32'h0);
        check("rst_mid_out", 32'(gpio_out), 32'h0);
        check("rst_mid_oe", 32'(gpio_oe), 32'h0);
        check("rst_mid_irq", 32'(irq), 32'h0);
        #1 mem_valid = 1'b0; mem_wstrb = 4'h0;
        @(negedge clk);
        #1 resetn = 1'b1;
        @(negedge clk); #1;
        bus(ra(0), 32'h0, 4'h0, 1'b1, rd);
        check("rst_mid_read_out", rd, 32'h0);
        bus(ra(1), 32'h0, 4'h0, 1'b1, rd);
        check("rst_mid_read_dir", rd, 32'h0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
